fixed_act_requant: RTL and testbench

Pipelined fixed-point requantizer placed directly downstream of the activation layers (fixed_softsign and siblings). It takes the wide activation output (28-bit), rounds it to nearest with ties toward +inf, saturates it to the narrow storage format, and forwards it over a valid/ready stream. A sticky saturation counter tracks precision loss for calibration.

---
 rtl/fixed_act_requant_pkg.sv | 16 +
 rtl/requant_pipe_stage.sv | 43 ++++
 rtl/fixed_act_requant.sv | 145 ++++++++++++++
 tb/tb_fixed_act_requant.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_act_requant_pkg.sv
// Shared constants and the saturating counter helper for the activation requantizer.
package fixed_act_requant_pkg;

    localparam int SAT_CNT_WIDTH = 16;
    localparam logic [SAT_CNT_WIDTH-1:0] SAT_CNT_MAX = 16'hFFFF;

    function automatic logic [SAT_CNT_WIDTH-1:0] sat_cnt_add(
        input logic [SAT_CNT_WIDTH-1:0] cnt,
        input logic [SAT_CNT_WIDTH-1:0] inc
    );
        logic [SAT_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[SAT_CNT_WIDTH] ? SAT_CNT_MAX : sum[SAT_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/requant_pipe_stage.sv
// Valid/ready register slice; accepts a new beat whenever it is empty or its consumer is ready.
module requant_pipe_stage #(
    parameter int WIDTH    = 8,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready
);

    assign d_ready = !q_valid || q_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid <= 1'b0;
        end else if (d_ready) begin
            q_valid <= d_valid;
        end
    end

    // Only the slice that drives the block output clears its payload on reset.
    if (CLR_DATA) begin : g_clr
        always_ff @(posedge clk) begin
            if (!rst) begin
                q <= '0;
            end else if (d_ready && d_valid) begin
                q <= d;
            end
        end
    end else begin : g_noclr
        always_ff @(posedge clk) begin
            if (d_ready && d_valid) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fixed_act_requant.sv
// Requantizer: round-half-up, saturate to the narrow format, two-stage valid/ready pipeline
// with a sticky count of saturated lanes.
module fixed_act_requant
    import fixed_act_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 28,
    parameter int DATA_IN_0_PRECISION_1       = 16,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 6,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [0:DATA_IN_0_PARALLELISM_DIM_0-1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [0:DATA_IN_0_PARALLELISM_DIM_0-1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    input  logic                              sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]          sat_count
);

    localparam int IN_W     = DATA_IN_0_PRECISION_0;
    localparam int IN_FRAC  = DATA_IN_0_PRECISION_1;
    localparam int OUT_W    = DATA_OUT_0_PRECISION_0;
    localparam int OUT_FRAC = DATA_OUT_0_PRECISION_1;
    localparam int P        = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int S        = IN_FRAC - OUT_FRAC;
    localparam int RND_W    = IN_W + 1 - S;
    localparam int RND_SH   = (S > 0) ? S - 1 : 0;

    localparam logic signed [IN_W:0]      RND   = (S > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic [OUT_W-1:0]          Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]          Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [RND_W-1:0]   R_MAX = {{(RND_W-OUT_W){1'b0}}, Q_MAX};
    localparam logic signed [RND_W-1:0]   R_MIN = {{(RND_W-OUT_W){1'b1}}, Q_MIN};

    if (IN_FRAC < OUT_FRAC) begin : g_bad_frac
        $error("fixed_act_requant: input fractional bits must be >= output fractional bits");
    end
    if (IN_W - IN_FRAC < OUT_W - OUT_FRAC) begin : g_bad_int
        $error("fixed_act_requant: input integer bits must be >= output integer bits");
    end
    if (DATA_OUT_0_PARALLELISM_DIM_0 != P) begin : g_bad_par
        $error("fixed_act_requant: output parallelism must equal input parallelism");
    end

    // One guard bit keeps x + 2^(S-1) from overflowing at the positive extreme.
    function automatic logic signed [RND_W-1:0] round_lane(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        sum = {x[IN_W-1], x} + RND;
        return RND_W'(sum >>> S);
    endfunction

    function automatic logic [OUT_W:0] clamp_lane(input logic signed [RND_W-1:0] r);
        if (r > R_MAX) begin
            return {1'b1, Q_MAX};
        end else if (r < R_MIN) begin
            return {1'b1, Q_MIN};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic [P*RND_W-1:0]         rnd_p0;
    logic [P*RND_W-1:0]         rnd_p1;
    logic                       vld_p1;
    logic                       rdy_p1;
    logic [P+P*OUT_W-1:0]       clp_p1;
    logic [P+P*OUT_W-1:0]       clp_p2;
    logic                       vld_p2;
    logic                       rdy_p2;
    logic [P-1:0]               sat_p2;
    logic [SAT_CNT_WIDTH-1:0]   sat_pop;
    logic [SAT_CNT_WIDTH-1:0]   sat_cnt;

    for (genvar i = 0; i < P; i++) begin : g_round
        assign rnd_p0[i*RND_W +: RND_W] = round_lane(data_in_0[i]);
    end

    // Stage 1: rounded lanes
    requant_pipe_stage #(
        .WIDTH    (P*RND_W),
        .CLR_DATA (1'b0)
    ) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .d       (rnd_p0),
        .d_valid (data_in_0_valid),
        .d_ready (rdy_p1),
        .q       (rnd_p1),
        .q_valid (vld_p1),
        .q_ready (rdy_p2)
    );

    assign data_in_0_ready = rdy_p1 && rst;

    for (genvar i = 0; i < P; i++) begin : g_clamp
        logic [OUT_W:0] clp;
        assign clp                        = clamp_lane(rnd_p1[i*RND_W +: RND_W]);
        assign clp_p1[i*OUT_W +: OUT_W]   = clp[OUT_W-1:0];
        assign clp_p1[P*OUT_W + i]        = clp[OUT_W];
    end

    // Stage 2: clamped lanes plus per-lane saturation flags
    requant_pipe_stage #(
        .WIDTH    (P + P*OUT_W),
        .CLR_DATA (1'b1)
    ) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .d       (clp_p1),
        .d_valid (vld_p1),
        .d_ready (rdy_p2),
        .q       (clp_p2),
        .q_valid (vld_p2),
        .q_ready (data_out_0_ready)
    );

    for (genvar i = 0; i < P; i++) begin : g_out
        assign data_out_0[i] = clp_p2[i*OUT_W +: OUT_W];
    end
    assign sat_p2           = clp_p2[P*OUT_W +: P];
    assign data_out_0_valid = vld_p2;

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < P; i++) begin
            sat_pop = sat_pop + SAT_CNT_WIDTH'(sat_p2[i]);
        end
    end

    // Clear beats any same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst || sat_clear) begin
            sat_cnt <= '0;
        end else if (vld_p2 && data_out_0_ready) begin
            sat_cnt <= sat_cnt_add(sat_cnt, sat_pop);
        end
    end

    assign sat_count = sat_cnt;

endmodule

// File: tb/tb_fixed_act_requant.sv
// Scoreboard bench for fixed_act_requant: directed vectors, stalls, reset, counter limits, random stress.
module tb_fixed_act_requant;

    localparam int IN_W  = 28;
    localparam int OUT_W = 8;
    localparam int P     = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IN_W-1:0]  data_in_0 [0:P-1];
    logic             data_in_0_valid = 1'b0;
    logic             data_in_0_ready;
    logic [OUT_W-1:0] data_out_0 [0:P-1];
    logic             data_out_0_valid;
    logic             data_out_0_ready = 1'b1;
    logic             sat_clear = 1'b0;
    logic [15:0]      sat_count;

    always #5 clk = ~clk;

    fixed_act_requant dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .sat_clear        (sat_clear),
        .sat_count        (sat_count)
    );

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic [1:0] sat;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   exp_cnt  = 0;
    bit   lat_mode = 1'b0;
    bit   mon_on   = 1'b0;
    bit   rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic signed [27:0] x0, input logic signed [27:0] x1,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] s);
        exp_t e;
        int   n;
        n = 0;
        data_in_0[0]    = x0;
        data_in_0[1]    = x1;
        data_in_0_valid = 1'b1;
        @(negedge clk);
        while (!data_in_0_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!data_in_0_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=ready_low required=ready_high at cycle %0d", cyc);
            data_in_0_valid = 1'b0;
        end else begin
            e = '{q0: e0, q1: e1, sat: s, acc: cyc, lat: lat_mode};
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        data_in_0_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: floor((x + 512) / 1024) computed by division, then clamp.
    function automatic void model(input logic signed [27:0] x, output logic [7:0] q, output bit s);
        longint v;
        longint f;
        v = longint'(x) + 512;
        f = v / 1024;
        if (v < 0 && (v % 1024) != 0) f = f - 1;
        if (f > 127) begin
            q = 8'h7F; s = 1'b1;
        end else if (f < -128) begin
            q = 8'h80; s = 1'b1;
        end else begin
            q = 8'(f); s = 1'b0;
        end
    endfunction

    task automatic send_model(input logic signed [27:0] x0, input logic signed [27:0] x1);
        logic [7:0] q0, q1;
        bit         s0, s1;
        model(x0, q0, s0);
        model(x1, q1, s1);
        send(x0, x1, q0, q1, {s1, s0});
    endtask

    function automatic logic signed [27:0] pick_x();
        int v;
        case ($urandom_range(0, 5))
            0:       return 28'sh8000000;
            1:       return 28'sh7FFFFFF;
            2:       return 28'($urandom);
            default: begin
                v = int'($urandom_range(0, 400000)) - 200000;
                return 28'(v);
            end
        endcase
    endfunction

    // Monitor: sat_count tracking, hold-under-stall, and output scoreboard.
    logic [7:0] prev0, prev1;
    bit         prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            check("sat_count", sat_count, exp_cnt);
            if (prev_stall) begin
                check("hold_valid", data_out_0_valid, 1);
                check("hold_lane0", data_out_0[0], prev0);
                check("hold_lane1", data_out_0[1], prev1);
            end
            prev_stall = data_out_0_valid && !data_out_0_ready && rst;
            prev0      = data_out_0[0];
            prev1      = data_out_0[1];
            if (!rst) begin
                sb.delete();
                exp_cnt = 0;
            end else begin
                if (data_out_0_valid && data_out_0_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h_%0h required=no_beat", data_out_0[0], data_out_0[1]);
                    end else begin
                        e = sb.pop_front();
                        check("lane0", data_out_0[0], e.q0);
                        check("lane1", data_out_0[1], e.q1);
                        if (e.lat) check("latency", cyc - e.acc, 2);
                        exp_cnt = exp_cnt + e.sat[0] + e.sat[1];
                        if (exp_cnt > 65535) exp_cnt = 65535;
                    end
                end
                if (sat_clear) exp_cnt = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        data_in_0[0] = '0;
        data_in_0[1] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", data_out_0_valid, 0);
        check("rst_lane0", data_out_0[0], 0);
        check("rst_lane1", data_out_0[1], 0);
        check("rst_count", sat_count, 0);
        check("rst_in_ready", data_in_0_ready, 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_on = 1'b1;

        // Basic rounding and clamp boundaries, latency checked
        lat_mode = 1'b1;
        send(28'sd65536, 28'sd1536, 8'd64, 8'd2, 2'b00);
        send(-28'sd1536, 28'sd511, 8'hFF, 8'd0, 2'b00);
        idle(4);
        lat_mode = 1'b0;

        // Saturation
        send(28'sd200000, -28'sd200000, 8'h7F, 8'h80, 2'b11);
        idle(4);
        @(negedge clk);
        check("sat_two", sat_count, 2);
        @(posedge clk);
        #1;
        send(28'sd130559, 28'sd130560, 8'h7F, 8'h7F, 2'b10);
        send(-28'sd131584, -28'sd131585, 8'h80, 8'h80, 2'b10);
        send(28'sh7FFFFFF, 28'sh8000000, 8'h7F, 8'h80, 2'b11);
        idle(4);

        // Back-pressure: 5 beats against a stalled output
        data_out_0_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    send(28'(k * 1024), 28'(-k * 1024), 8'(k), 8'(-k), 2'b00);
                end
                data_in_0_valid = 1'b0;
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                check("bp_accepts", acc_cnt, 2);
                check("bp_in_ready", data_in_0_ready, 0);
                check("bp_valid", data_out_0_valid, 1);
                @(posedge clk);
                #1;
                data_out_0_ready = 1'b1;
            end
        join
        idle(6);
        check("bp_drain", sb.size(), 0);
        check("bp_total", acc_cnt, 5);

        // Mid-stall reset
        data_out_0_ready = 1'b0;
        send(28'sd300000, -28'sd300000, 8'h7F, 8'h80, 2'b11);
        send(28'sd2048, 28'sd0, 8'd2, 8'd0, 2'b00);
        idle(3);
        rst = 1'b0;
        data_out_0_ready = 1'b1;
        @(negedge clk);
        check("rst_forces_in_ready", data_in_0_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", data_out_0_valid, 0);
        check("mid_rst_lane0", data_out_0[0], 0);
        check("mid_rst_lane1", data_out_0[1], 0);
        check("mid_rst_count", sat_count, 0);
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(28'sd3072, -28'sd3072, 8'd3, 8'hFD, 2'b00);
        idle(4);

        // Counter saturation at 0xFFFF, then clear racing a saturating handshake
        for (int k = 0; k < 32770; k++) begin
            send(28'sd200000, -28'sd200000, 8'h7F, 8'h80, 2'b11);
        end
        lat_mode = 1'b0;
        idle(4);
        @(negedge clk);
        check("cnt_max", sat_count, 16'hFFFF);
        @(posedge clk);
        #1;
        send(28'sd200000, -28'sd200000, 8'h7F, 8'h80, 2'b11);
        data_in_0_valid = 1'b0;
        @(posedge clk);
        #1;
        sat_clear = 1'b1;
        @(negedge clk);
        check("clr_hs_valid", data_out_0_valid, 1);
        @(posedge clk);
        #1;
        sat_clear = 1'b0;
        @(negedge clk);
        check("clr_wins", sat_count, 0);
        @(posedge clk);
        #1;

        // Random stress
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10000; k++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send_model(pick_x(), pick_x());
                end
                data_in_0_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    data_out_0_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        data_out_0_ready = 1'b1;

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
